// File: rtl/sdram_rd_buf.sv
// sdram_rd_buf: windowed SDRAM read requester feeding a first-word-fall-through buffer.
// Define SDRAM_RD_BUF_STAT_EN to add txn_cnt and level_max statistics outputs.
module sdram_rd_buf #(
    parameter int          FIFO_DEPTH = 512,
    parameter int          REQ_BURSTS = 8,
    parameter int          BURST_LEN  = 4,
    parameter logic [20:0] ADDR_BASE  = 21'h000000,
    parameter logic [20:0] ADDR_TOP   = 21'h1FFFFF,
    localparam int         AW         = $clog2(FIFO_DEPTH),
    localparam int         LW         = AW + 1
) (
    input  logic          sclk,
    input  logic          srst_n,
    input  logic          stream_en,
    input  logic          flush,
    output logic          rd_trig,
    output logic [7:0]    rd_len,
    output logic [20:0]   rd_addr,
    input  logic [15:0]   rd_data,
    input  logic          rd_data_en,
    output logic [15:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [LW-1:0] fifo_level,
    output logic          busy,
    output logic          overflow
`ifdef SDRAM_RD_BUF_STAT_EN
    ,
    output logic [15:0]   txn_cnt,
    output logic [LW-1:0] level_max
`endif
);

    localparam int            REQ_WORDS = REQ_BURSTS * BURST_LEN;
    localparam int            CW        = $clog2(REQ_WORDS + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] REQ_L     = LW'(REQ_WORDS);
    localparam logic [CW-1:0] REQ_C     = CW'(REQ_WORDS);
    localparam logic [21:0]   REQ_A     = 22'(REQ_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_TRIG, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [20:0]   addr_q, addr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic          do_flush;
    logic          full;
    logic          pop;
    logic          push;
    logic          done;
    logic [21:0]   addr_sum;

    assign do_flush = (state_q == S_IDLE) && flush;
    assign full     = (level_q == DEPTH_L);
    assign pop      = dout_valid && dout_ready;
    assign push     = rd_data_en && (!full || pop) && !do_flush;
    assign addr_sum = {1'b0, addr_q} + REQ_A;
    assign done     = (state_q == S_WAIT) && rd_data_en
                      && ((rx_cnt_q + CW'(1)) == REQ_C);

    // Requests only launch when the whole transaction is guaranteed to fit.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rx_cnt_d = rx_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    addr_d = ADDR_BASE;
                end else if (stream_en) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!stream_en) begin
                    state_d = S_IDLE;
                end else if ((DEPTH_L - level_q) >= REQ_L) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                rx_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (rd_data_en) begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
                if (done) begin
                    state_d = stream_en ? S_CHECK : S_IDLE;
                    addr_d  = (addr_sum > {1'b0, ADDR_TOP}) ? ADDR_BASE
                                                            : addr_sum[20:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (rd_data_en && !push) begin
                ovf_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= ADDR_BASE;
            rx_cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rx_cnt_q <= rx_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; dout is masked until a word is present.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rd_data;
        end
    end

    assign dout_valid = (level_q != '0);
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign rd_trig    = (state_q == S_TRIG);
    assign busy       = (state_q == S_WAIT);
    assign rd_len     = 8'(REQ_BURSTS);
    assign rd_addr    = addr_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

`ifdef SDRAM_RD_BUF_STAT_EN
    logic [15:0]   txn_cnt_q, txn_cnt_d;
    logic [LW-1:0] lmax_q, lmax_d;

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        lmax_d    = lmax_q;
        if (do_flush) begin
            txn_cnt_d = '0;
            lmax_d    = '0;
        end else begin
            if (done && (txn_cnt_q != 16'hFFFF)) begin
                txn_cnt_d = txn_cnt_q + 16'd1;
            end
            if (level_q > lmax_q) begin
                lmax_d = level_q;
            end
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            txn_cnt_q <= '0;
            lmax_q    <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
            lmax_q    <= lmax_d;
        end
    end

    assign txn_cnt   = txn_cnt_q;
    assign level_max = lmax_q;
`endif

endmodule

// File: doc/sdram_rd_buf.md
Name: sdram_rd_buf

Overview:
- Streaming read front-end that sits directly upstream of the SDRAM read engine.
- Issues read transactions (rd_trig/rd_len/rd_addr) over a programmable address window.
- Captures the returned rd_data/rd_data_en words into an internal synchronous FIFO.
- Presents the data to the user side on a valid/ready interface, so the consumer never stalls the SDRAM.

Parameters:
- FIFO_DEPTH, 512: buffer depth in 16-bit words; power of 2, at least 2*REQ_WORDS.
- REQ_BURSTS, 8: bursts per transaction, driven on rd_len; 1..255.
- BURST_LEN, 4: words per burst returned by the read engine.
- ADDR_BASE, 21'h000000: first word address of the window.
- ADDR_TOP, 21'h1FFFFF: last word address of the window (inclusive).

Ports:
- sclk  in  1  clock
- srst_n  in  1  reset
- stream_en  in  1  level; 1 = keep fetching
- flush  in  1  pulse; clear FIFO and restart at ADDR_BASE (honoured only in S_IDLE)
- rd_trig  out  1  one-cycle transaction request to read engine
- rd_len  out  8  burst count, constant REQ_BURSTS
- rd_addr  out  21  start word address {row[20:9], col[8:0]}
- rd_data  in  16  read-engine data
- rd_data_en  in  1  rd_data valid this cycle
- dout  out  16  user data
- dout_valid  out  1  dout holds a word
- dout_ready  in  1  user accepts word when valid&ready
- fifo_level  out  log2(FIFO_DEPTH)+1  words stored, including the dout word
- busy  out  1  transaction outstanding
- overflow  out  1  sticky: word dropped because FIFO full

Behaviour:
- Reset: srst_n, asynchronous, active-low; clock sclk. All outputs reset to 0, except rd_len, which is constant REQ_BURSTS. Next address resets to ADDR_BASE, FIFO is empty, FSM is S_IDLE.
- REQ_WORDS = REQ_BURSTS*BURST_LEN.
- FSM states: S_IDLE, S_CHECK, S_TRIG, S_WAIT.
- S_IDLE:
  - flush=1: empty FIFO, next_addr=ADDR_BASE, clear overflow; remain S_IDLE.
  - Else stream_en=1 -> S_CHECK.
- S_CHECK:
  - stream_en=0 -> S_IDLE.
  - Else if (FIFO_DEPTH - fifo_level) >= REQ_WORDS -> S_TRIG.
  - Else stay.
  - This space reservation guarantees no overflow under correct read-engine behaviour.
- S_TRIG:
  - rd_trig=1 for exactly one cycle, with rd_addr=next_addr.
  - Clear rx_cnt; -> S_WAIT.
- S_WAIT:
  - busy=1; rx_cnt increments on each rd_data_en.
  - When rx_cnt reaches REQ_WORDS (counting the final word's cycle), go to S_CHECK, or to S_IDLE if stream_en=0.
  - Advance next_addr in the same cycle: next_addr+REQ_WORDS, or ADDR_BASE if next_addr+REQ_WORDS > ADDR_TOP. Compare in 22-bit arithmetic; no 21-bit wrap.
  - stream_en dropping in S_WAIT does not abort; the transaction completes (read engine cannot be cancelled).
  - flush in S_WAIT is ignored.
- rd_data_en outside S_WAIT: word still pushed if space, never counted; no state change.
- FIFO:
  - Push on rd_data_en when not full. If full, drop the word and set overflow (sticky until flush or reset).
  - Pop on dout_valid & dout_ready.
  - First-word-fall-through, registered: a word pushed into an empty FIFO appears on dout with dout_valid=1 the next cycle.
  - Simultaneous push and pop: both performed; level unchanged. At full with simultaneous pop, the push is accepted.
  - dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
- fifo_level updates the cycle after push/pop.
- rd_len is constant REQ_BURSTS; rd_addr holds next_addr at all times.

Optional Feature:
- SDRAM_RD_BUF_STAT_EN defined: adds output txn_cnt (16 bits) and output level_max (log2(FIFO_DEPTH)+1 bits).
  - txn_cnt: completed transactions, saturating at 16'hFFFF.
  - level_max: peak fifo_level watermark.
  - Both clear on reset and on flush.
- Macro undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Test configuration: FIFO_DEPTH=64, REQ_BURSTS=2, ADDR_BASE=0, ADDR_TOP=15.
- Basic fetch: stream_en=1, dout_ready=1, read-engine model returns 8 words 0..7 -> rd_trig pulses with rd_addr=0; then rd_trig with rd_addr=8; dout sequence 0..7 in order, no gaps other than engine latency.
- Wrap: after the transaction at rd_addr=8 completes -> next rd_trig has rd_addr=0 (8+8>15); overflow stays 0.
- Backpressure: dout_ready=0, engine always responds -> exactly 8 transactions issued, fifo_level=64, FSM holds in S_CHECK; then assert dout_ready -> a new rd_trig fires once fifo_level<=56.
- Stop mid-transaction: deassert stream_en after rd_trig, 3 words received -> remaining 5 words still captured, busy falls after the 8th word, FSM reaches S_IDLE, no further rd_trig.
- Overflow/flush: inject 10 spurious rd_data_en words with the FIFO full -> overflow=1, fifo_level=64; flush in S_IDLE -> fifo_level=0, overflow=0, dout_valid=0, next rd_addr=0.
- Simultaneous push/pop at empty: single word pushed while dout_ready=1 -> dout_valid=1 for one cycle, fifo_level 0->1->0; with SDRAM_RD_BUF_STAT_EN, txn_cnt increments by 1 per completed transaction.
